mem_arbiter: RTL and testbench

Two-requester arbiter for the single-port unified memory of the multicycle RISC-V system. Requester 0 is the `riscvmulti` core; requester 1 is a secondary master such as a program loader, DMA or debug port. The block shares the memory between them with round-robin priority, an optional lock for atomic sequences, and a registered read-data return. It sits between the masters and `mem`, driving the memory's `we`, `a` and `wd` inputs and sampling its combinational `rd` output.

---
 rtl/mem_arbiter.sv | 66 ++++++
 tb/tb_mem_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter for a single-port memory, with lock and registered read return
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);
  typedef enum logic [1:0] {NONE, OWN0, OWN1} owner_t;
  owner_t owner, owner_n;
  logic prio, prio_n, c0, c1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= NONE;
      prio  <= 1'b0;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
      rd0   <= '0;
      rd1   <= '0;
    end else begin
      owner <= owner_n;
      prio  <= prio_n;
      rv0   <= m0_gnt && !m0_we;
      rv1   <= m1_gnt && !m1_we;
      if (m0_gnt && !m0_we) rd0 <= mem_rd;
      if (m1_gnt && !m1_we) rd1 <= mem_rd;
    end
  end
  always_comb begin
    c0 = owner == OWN0 ? m0_req : owner == OWN1 ? 1'b0 : m0_req && !(m1_req && prio);
    c1 = owner == OWN1 ? m1_req : owner == OWN0 ? 1'b0 : m1_req && !(m0_req && !prio);
    m0_gnt = c0 && !reset;
    m1_gnt = c1 && !reset;
    owner_n = m0_gnt ? (m0_lock ? OWN0 : NONE) : m1_gnt ? (m1_lock ? OWN1 : NONE) : owner;
    prio_n = (m0_gnt && !m0_lock) ? 1'b1 : (m1_gnt && !m1_lock) ? 1'b0 : prio;
  end
  // with no winner the bus idles on requester 0's inputs
  assign mem_we    = m0_gnt ? m0_we : m1_gnt && m1_we;
  assign mem_a     = m1_gnt ? m1_addr : m0_addr;
  assign mem_wd    = m1_gnt ? m1_wdata : m0_wdata;
  assign m0_rvalid = rv0 && !reset;
  assign m1_rvalid = rv1 && !reset;
  assign m0_rdata  = reset ? '0 : rd0;
  assign m1_rdata  = reset ? '0 : rd1;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven check of mem_arbiter against a behavioural memory
module tb_mem_arbiter;
  logic clk = 0, reset = 1;
  logic m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_a, mem_wd, mem_rd;
  logic [31:0] mem [0:255];
  int checks = 0, failures = 0, cur = 0;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

  typedef struct {
    logic rst, r0, w0, l0;
    logic [31:0] a0, d0;
    logic r1, w1, l1;
    logic [31:0] a1, d1;
    logic g0, g1, we;
    logic [31:0] ea;
    logic rv0, rv1;
    logic [31:0] rd0, rd1;
  } vec_t;
  vec_t q[$];
  localparam logic [31:0] D = 32'hDEADBEEF;

  task automatic add(input logic rst, r0, w0, l0, input logic [31:0] a0, d0,
                     input logic r1, w1, l1, input logic [31:0] a1, d1,
                     input logic g0, g1, we, input logic [31:0] ea,
                     input logic rv0, rv1, input logic [31:0] rd0, rd1);
    q.push_back('{rst, r0, w0, l0, a0, d0, r1, w1, l1, a1, d1, g0, g1, we, ea, rv0, rv1, rd0, rd1});
  endtask

  task automatic chk(input string n, input logic [31:0] a, e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", n, cur, a, e);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 0;
    mem['h10 >> 2] = D;
    //  rst r0 w0 l0 a0    d0       r1 w1 l1 a1    d1         g0 g1 we ea     rv0 rv1 rd0  rd1
    add(1,  1, 0, 0, 'h10, 0,       1, 1, 0, 'h80, 7,         0, 0, 0, 'h10,  0, 0, 0,     0);
    add(0,  0, 0, 0, 0,    0,       0, 0, 0, 0,    0,         0, 0, 0, 0,     0, 0, 0,     0);
    add(0,  1, 0, 0, 'h10, 0,       0, 0, 0, 0,    0,         1, 0, 0, 'h10,  0, 0, 0,     0);
    add(0,  0, 0, 0, 0,    0,       0, 0, 0, 0,    0,         0, 0, 0, 0,     1, 0, D,     0);
    add(1,  1, 0, 0, 'h10, 0,       1, 1, 0, 'h80, 'h77,      0, 0, 0, 'h10,  0, 0, 0,     0);
    add(0,  1, 0, 0, 'h10, 0,       1, 1, 0, 'h80, 'h77,      1, 0, 0, 'h10,  0, 0, 0,     0);
    add(0,  1, 0, 0, 'h10, 0,       1, 1, 0, 'h80, 'h77,      0, 1, 1, 'h80,  1, 0, D,     0);
    add(0,  1, 0, 0, 'h80, 0,       1, 1, 0, 'h80, 'h78,      1, 0, 0, 'h80,  0, 0, D,     0);
    add(0,  1, 0, 0, 'h80, 0,       1, 1, 0, 'h80, 'h78,      0, 1, 1, 'h80,  1, 0, 'h77,  0);
    add(0,  1, 0, 0, 'h80, 0,       1, 1, 0, 'h80, 'h79,      1, 0, 0, 'h80,  0, 0, 'h77,  0);
    add(0,  1, 0, 0, 'h80, 0,       1, 1, 0, 'h80, 'h79,      0, 1, 1, 'h80,  1, 0, 'h78,  0);
    add(0,  0, 0, 0, 0,    0,       0, 0, 0, 0,    0,         0, 0, 0, 0,     0, 0, 'h78,  0);
    add(0,  1, 0, 0, 'h10, 0,       0, 0, 0, 0,    0,         1, 0, 0, 'h10,  0, 0, 'h78,  0);
    add(0,  1, 0, 0, 'h10, 0,       1, 1, 1, 'h20, 'h55,      0, 1, 1, 'h20,  1, 0, D,     0);
    add(0,  1, 0, 0, 'h10, 0,       1, 0, 0, 'h20, 0,         0, 1, 0, 'h20,  0, 0, D,     0);
    add(0,  1, 0, 0, 'h10, 0,       0, 0, 0, 0,    0,         1, 0, 0, 'h10,  0, 1, D,     'h55);
    add(0,  1, 0, 1, 'h10, 0,       0, 0, 0, 0,    0,         1, 0, 0, 'h10,  1, 0, D,     'h55);
    add(0,  0, 0, 0, 0,    0,       1, 1, 0, 'h40, 'h1234,    0, 0, 0, 0,     1, 0, D,     'h55);
    add(0,  1, 0, 1, 'h10, 0,       1, 1, 0, 'h40, 'h1234,    1, 0, 0, 'h10,  0, 0, D,     'h55);
    add(1,  0, 0, 0, 0,    0,       1, 1, 0, 'h40, 'h1234,    0, 0, 0, 0,     0, 0, 0,     0);
    add(0,  0, 0, 0, 0,    0,       1, 1, 0, 'h40, 'h1234,    0, 1, 1, 'h40,  0, 0, 0,     0);
    add(0,  1, 0, 0, 'h40, 0,       0, 0, 0, 0,    0,         1, 0, 0, 'h40,  0, 0, 0,     0);
    add(0,  0, 0, 0, 0,    0,       0, 0, 0, 0,    0,         0, 0, 0, 0,     1, 0, 'h1234, 0);
    foreach (q[i]) begin
      @(negedge clk);
      cur = i;
      reset = q[i].rst;
      {m0_req, m0_we, m0_lock, m0_addr, m0_wdata} = {q[i].r0, q[i].w0, q[i].l0, q[i].a0, q[i].d0};
      {m1_req, m1_we, m1_lock, m1_addr, m1_wdata} = {q[i].r1, q[i].w1, q[i].l1, q[i].a1, q[i].d1};
      #1;
      chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, q[i].g0});
      chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, q[i].g1});
      chk("mem_we", {31'b0, mem_we}, {31'b0, q[i].we});
      chk("mem_a", mem_a, q[i].ea);
      chk("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, q[i].rv0});
      chk("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, q[i].rv1});
      chk("m0_rdata", m0_rdata, q[i].rd0);
      chk("m1_rdata", m1_rdata, q[i].rd1);
    end
    // back-to-back reads by requester 1: one grant and one rvalid per cycle
    begin
      logic [31:0] ad [3];
      logic [31:0] ex [3];
      ad = '{32'h20, 32'h40, 32'h10};
      ex = '{32'h55, 32'h1234, D};
      for (int i = 0; i <= 3; i++) begin
        @(negedge clk);
        cur = 100 + i;
        m0_req = 0;
        m1_req = i < 3;
        m1_we = 0;
        m1_lock = 0;
        m1_addr = i < 3 ? ad[i] : 0;
        #1;
        chk("b2b_gnt", {31'b0, m1_gnt}, {31'b0, i < 3});
        if (i > 0) begin
          chk("b2b_rvalid", {31'b0, m1_rvalid}, 1);
          chk("b2b_rdata", m1_rdata, ex[i-1]);
        end
      end
    end
    // bounded wait: requester 1 must win within one cycle of contention
    begin
      int n = 0;
      @(negedge clk);
      cur = 200;
      m0_req = 1; m0_we = 0; m0_addr = 'h10;
      m1_req = 1; m1_we = 0; m1_addr = 'h20;
      #1;
      while (!m1_gnt && n < 4) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("wait_m1_gnt", {31'b0, m1_gnt}, 1);
      chk("wait_cycles", n, 1);
      @(negedge clk);
      m0_req = 0; m1_req = 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
